// File: rtl/div_iter.sv
// Iterative radix-2 restoring divider for DIV/DIVU in the execute stage.
// Quotient goes to LO and remainder goes to HI. The unit takes WIDTH+1 cycles
// after start is sampled: WIDTH CALC cycles, then one FINISH cycle with done.
// WIDTH must be at least 2.

module div_iter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LastStep = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StFinish
  } state_e;

  state_e state_q;

  // Operation context latched when start is accepted
  logic             signed_q;
  logic             neg_dividend_q;
  logic             neg_divisor_q;
  logic [WIDTH-1:0] dividend_raw_q;
  logic [WIDTH-1:0] divisor_mag_q;

  // Datapath: partial remainder and quotient shift register.
  // quo_q starts out holding the dividend magnitude and is shifted out MSB first
  // while quotient bits shift in at the LSB.
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [CW-1:0]    count_q;
  logic             done_q;

  // Magnitudes of the incoming operands
  logic             in_neg_dividend;
  logic             in_neg_divisor;
  logic [WIDTH-1:0] in_dividend_mag;
  logic [WIDTH-1:0] in_divisor_mag;

  // One restoring step
  logic [WIDTH:0]   cand;
  logic [WIDTH+1:0] diff;
  logic             fits;
  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-1:0] quo_next;

  // Final, sign-corrected result
  logic [WIDTH-1:0] q_final;
  logic [WIDTH-1:0] r_final;

  // Convert the incoming operands to magnitudes when dividing signed
  always_comb begin
    in_neg_dividend = is_signed & dividend[WIDTH-1];
    in_neg_divisor  = is_signed & divisor[WIDTH-1];
    in_dividend_mag = in_neg_dividend ? (~dividend + 1'b1) : dividend;
    in_divisor_mag  = in_neg_divisor  ? (~divisor + 1'b1)  : divisor;
  end

  // Shift-and-trial-subtract; the extra top bit of diff is the borrow
  always_comb begin
    cand     = {rem_q, quo_q[WIDTH-1]};
    diff     = {1'b0, cand} - {2'b00, divisor_mag_q};
    fits     = ~diff[WIDTH+1];
    // When the trial fits the difference is below the divisor, so it fits WIDTH bits
    rem_next = fits ? diff[WIDTH-1:0] : cand[WIDTH-1:0];
    quo_next = {quo_q[WIDTH-2:0], fits};
  end

  // Apply divide-by-zero override or sign correction to the last step's result
  always_comb begin
    q_final = quo_next;
    r_final = rem_next;
    if (divisor_mag_q == '0) begin
      q_final = '1;
      r_final = dividend_raw_q;
    end else if (signed_q) begin
      if (neg_dividend_q ^ neg_divisor_q) begin
        q_final = ~quo_next + 1'b1;
      end
      // Remainder takes the sign of the dividend
      if (neg_dividend_q) begin
        r_final = ~rem_next + 1'b1;
      end
    end
  end

  // Control FSM and datapath registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q        <= StIdle;
      signed_q       <= 1'b0;
      neg_dividend_q <= 1'b0;
      neg_divisor_q  <= 1'b0;
      dividend_raw_q <= '0;
      divisor_mag_q  <= '0;
      rem_q          <= '0;
      quo_q          <= '0;
      count_q        <= '0;
      done_q         <= 1'b0;
      quotient       <= '0;
      remainder      <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start && !flush) begin
            signed_q       <= is_signed;
            neg_dividend_q <= in_neg_dividend;
            neg_divisor_q  <= in_neg_divisor;
            dividend_raw_q <= dividend;
            divisor_mag_q  <= in_divisor_mag;
            rem_q          <= '0;
            quo_q          <= in_dividend_mag;
            count_q        <= '0;
            state_q        <= StCalc;
          end
        end
        StCalc: begin
          if (flush) begin
            state_q <= StIdle;
          end else begin
            rem_q   <= rem_next;
            quo_q   <= quo_next;
            count_q <= count_q + 1'b1;
            if (count_q == LastStep) begin
              count_q   <= '0;
              state_q   <= StFinish;
              done_q    <= 1'b1;
              quotient  <= q_final;
              remainder <= r_final;
            end
          end
        end
        StFinish: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  // busy is a pure state decode so start never reaches it combinationally.
  // A flush landing on the FINISH cycle cancels that cycle's done.
  always_comb begin
    busy = (state_q == StCalc);
    done = done_q & ~flush;
  end

endmodule

// File: tb/tb_div_iter.sv
// Self-checking bench for div_iter: a cycle-level reference model compared
// every cycle, plus directed operations with hand-computed results.

module tb_div_iter;

  localparam int W = 32;

  logic          clk;
  logic          resetn;
  logic          start;
  logic          is_signed;
  logic [W-1:0]  dividend;
  logic [W-1:0]  divisor;
  logic          flush;
  logic          busy;
  logic          done;
  logic [W-1:0]  quotient;
  logic [W-1:0]  remainder;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  div_iter #(.WIDTH(W)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .start     (start),
    .is_signed (is_signed),
    .dividend  (dividend),
    .divisor   (divisor),
    .flush     (flush),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference quotient/remainder from plain arithmetic; returns {r, q}
  function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                          input logic s);
    longint sa;
    longint sb;
    logic [31:0] q;
    logic [31:0] r;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (s) begin
      sa = $signed(a);
      sb = $signed(b);
      q  = 32'(sa / sb);
      r  = 32'(sa % sb);
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  // Model: m_cnt counts cycles since an accepted start (0 = nothing running)
  int          m_cnt;
  logic [31:0] m_a, m_b, m_q, m_r;
  logic        m_s;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_cnt <= 0;
      m_q   <= '0;
      m_r   <= '0;
      m_a   <= '0;
      m_b   <= '0;
      m_s   <= 1'b0;
    end else if (m_cnt == 0) begin
      if (start && !flush) begin
        m_cnt <= 1;
        m_a   <= dividend;
        m_b   <= divisor;
        m_s   <= is_signed;
      end
    end else if (flush) begin
      m_cnt <= 0;
    end else if (m_cnt == W) begin
      m_cnt <= W + 1;
      m_q   <= ref_div(m_a, m_b, m_s)[31:0];
      m_r   <= ref_div(m_a, m_b, m_s)[63:32];
    end else if (m_cnt == W + 1) begin
      m_cnt <= 0;
    end else begin
      m_cnt <= m_cnt + 1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (resetn) begin
      check("busy", 32'(busy), 32'((m_cnt >= 1) && (m_cnt <= W)));
      check("done", 32'(done), 32'((m_cnt == W + 1) && !flush));
      check("quotient", quotient, m_q);
      check("remainder", remainder, m_r);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic goto(input int target);
    while (cyc < target) step();
  endtask

  // Caller is just after a rising edge; start is held for this one cycle
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s,
                       output int c0);
    start     = 1'b1;
    dividend  = a;
    divisor   = b;
    is_signed = s;
    c0        = cyc;
    step();
    start     = 1'b0;
    dividend  = $urandom;
    divisor   = $urandom;
    is_signed = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_done(output int seen);
    seen = -1;
    for (int i = 0; i < 80 && seen < 0; i++) begin
      @(negedge clk);
      if (done === 1'b1) seen = cyc;
    end
  endtask

  task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                        input logic s, input logic [31:0] eq, input logic [31:0] er);
    int c0;
    int seen;
    step();
    issue(a, b, s, c0);
    wait_done(seen);
    check({name, " done cycle"}, 32'(seen), 32'(c0 + 33));
    check({name, " q"}, quotient, eq);
    check({name, " r"}, remainder, er);
    check({name, " model q"}, m_q, eq);
    check({name, " model r"}, m_r, er);
  endtask

  initial begin
    int c0;
    int c1;
    int seen;
    resetn    = 1'b0;
    start     = 1'b0;
    is_signed = 1'b0;
    dividend  = '0;
    divisor   = '0;
    flush     = 1'b0;
    #1;
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset q", quotient, 32'd0);
    check("reset r", remainder, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;

    run_op("divu 100/7", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2);
    run_op("div -7/2", 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
    run_op("div 7/-2", 32'd7, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1);
    run_op("div ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0);
    run_op("divu max/1", 32'hFFFF_FFFF, 32'd1, 1'b0, 32'hFFFF_FFFF, 32'd0);
    run_op("divu /0", 32'h1234_5678, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'h1234_5678);
    run_op("div -5/0", 32'hFFFF_FFFB, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFB);

    // Flush mid-operation, then restart two cycles later
    step();
    issue(32'd500, 32'd9, 1'b0, c0);
    goto(c0 + 10);
    flush = 1'b1;
    goto(c0 + 11);
    flush = 1'b0;
    @(negedge clk);
    check("flush busy", 32'(busy), 32'd0);
    check("flush q kept", quotient, 32'hFFFF_FFFF);
    check("flush r kept", remainder, 32'hFFFF_FFFB);
    goto(c0 + 12);
    issue(32'd1000, 32'd3, 1'b0, c1);
    wait_done(seen);
    check("restart done cycle", 32'(seen), 32'(c0 + 45));
    check("restart q", quotient, 32'd333);
    check("restart r", remainder, 32'd1);

    // Start while busy is ignored
    step();
    issue(32'd55, 32'd5, 1'b0, c0);
    goto(c0 + 5);
    start    = 1'b1;
    dividend = 32'd1;
    divisor  = 32'd1;
    goto(c0 + 6);
    start    = 1'b0;
    wait_done(seen);
    check("busy start done cycle", 32'(seen), 32'(c0 + 33));
    check("busy start q", quotient, 32'd11);
    check("busy start r", remainder, 32'd0);

    // Flush coinciding with FINISH suppresses done
    step();
    issue(32'd77, 32'd10, 1'b0, c0);
    goto(c0 + 33);
    flush = 1'b1;
    @(negedge clk);
    check("finish flush done", 32'(done), 32'd0);
    check("finish flush q", quotient, 32'd7);
    goto(c0 + 34);
    flush = 1'b0;

    // Start held through FINISH: accepted only in the following cycle
    step();
    issue(32'hFFFF_FF9C, 32'd7, 1'b1, c0);
    goto(c0 + 33);
    start     = 1'b1;
    dividend  = 32'd9;
    divisor   = 32'd4;
    is_signed = 1'b0;
    @(negedge clk);
    check("b2b first done", 32'(done), 32'd1);
    check("b2b first q", quotient, 32'hFFFF_FFF2);
    check("b2b first r", remainder, 32'hFFFF_FFFE);
    goto(c0 + 34);
    c1 = cyc;
    goto(c0 + 35);
    start = 1'b0;
    wait_done(seen);
    check("b2b second done cycle", 32'(seen), 32'(c1 + 33));
    check("b2b second q", quotient, 32'd2);
    check("b2b second r", remainder, 32'd1);

    // Mixed operands checked against the model each cycle
    for (int i = 0; i < 12; i++) begin
      logic [31:0] a;
      logic [31:0] b;
      a = $urandom;
      b = (i % 3 == 0) ? 32'($urandom_range(1, 300)) : $urandom;
      if (i % 4 == 1) b = -b;
      step();
      issue(a, b, 1'(i % 2), c0);
      wait_done(seen);
      check("mixed done cycle", 32'(seen), 32'(c0 + 33));
    end

    // Asynchronous reset during CALC clears outputs immediately
    step();
    issue(32'd1234, 32'd5, 1'b0, c0);
    goto(c0 + 5);
    #2;
    resetn = 1'b0;
    #1;
    check("async rst busy", 32'(busy), 32'd0);
    check("async rst done", 32'(done), 32'd0);
    check("async rst q", quotient, 32'd0);
    check("async rst r", remainder, 32'd0);
    step();
    resetn = 1'b1;
    run_op("after reset", 32'd1234, 32'd5, 1'b0, 32'd246, 32'd4);

    repeat (3) step();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "timeout");
  end

endmodule
